// File: rtl/buffer_ser.sv
// Addressable word buffer that serialises its whole contents LSB-first on a start request.
// Optional macro BUFFER_SER_PARITY_EN appends an even-parity bit after the payload.
module buffer_ser #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int PAYLOAD = DEPTH * DATA_W;
`ifdef BUFFER_SER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int BASE_W = (ADDR_W + $clog2(DATA_W) < 1) ? 1 : ADDR_W + $clog2(DATA_W);
    // The parity bit sits at index PAYLOAD, which needs one extra counter bit.
    localparam int CNT_W = BASE_W + PAR_BITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD + PAR_BITS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [PAYLOAD-1:0] payload_bits;
    logic               stream_bit;

    always_comb begin
        payload_bits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            payload_bits[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    always_comb begin
        stream_bit = payload_bits[cnt_q[BASE_W-1:0]];
`ifdef BUFFER_SER_PARITY_EN
        if (cnt_q == LAST) begin
            stream_bit = ^payload_bits;
        end
`endif
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == IDLE && wr_en) begin
            mem_d[addr_in] = data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == SHIFT);
        busy      = (state_q == SHIFT);
        data_out  = (state_q == SHIFT) && stream_bit;
        done      = (state_q == SHIFT) && (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory keeps its contents through reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_buffer_ser.sv
// Scoreboard bench for buffer_ser: default instance plus a DATA_W=1/ADDR_W=1 instance.
// Expected stream bits come from a model memory and are queued when start is driven.
module tb_buffer_ser;

`ifdef BUFFER_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN = 64 + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] addr_in;
    logic [3:0] data_in;
    logic       start;
    logic       data_out;
    logic       out_valid;
    logic       busy;
    logic       done;

    logic       wr_en_s;
    logic [0:0] addr_s;
    logic [0:0] data_s;
    logic       start_s;
    logic       dout_s;
    logic       valid_s;
    logic       busy_s;
    logic       done_s;

    int         checks = 0;
    int         errors = 0;
    int         stream_no = 0;
    logic       exp_q[$];
    logic [3:0] model_mem[16];

    buffer_ser #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .start    (start),
        .data_out (data_out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    buffer_ser #(.DATA_W(1), .ADDR_W(1)) dut_small (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .addr_in  (addr_s),
        .data_in  (data_s),
        .start    (start_s),
        .data_out (dout_s),
        .out_valid(valid_s),
        .busy     (busy_s),
        .done     (done_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one edge's worth of inputs from a negedge, then return to 0 at the next negedge.
    task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [3:0] d,
                                 input logic s, input logic r);
        wr_en   = w;
        addr_in = a;
        data_in = d;
        start   = s;
        rst     = r;
        @(negedge clk);
        wr_en   = 1'b0;
        addr_in = '0;
        data_in = '0;
        start   = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 16'(out_valid), 16'h0);
        checkOutput({tag, "_busy"},  16'(busy),      16'h0);
        checkOutput({tag, "_done"},  16'(done),      16'h0);
        checkOutput({tag, "_data"},  16'(data_out),  16'h0);
    endtask

    task automatic pushExpected();
        logic p;
        p = 1'b0;
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(model_mem[w][b]);
                p = p ^ model_mem[w][b];
            end
        end
        if (PAR == 1) exp_q.push_back(p);
    endtask

    task automatic beginStream(input logic w, input logic [3:0] a, input logic [3:0] d);
        if (w) model_mem[a] = d;
        pushExpected();
        applyStimulus(w, a, d, 1'b1, 1'b0);
    endtask

    // Walk the stream one bit per cycle; optionally inject a write+start or a reset mid-stream.
    task automatic runStream(input int inject_at, input int abort_at);
        logic e;
        stream_no++;
        for (int i = 0; i < LEN; i++) begin
            if (exp_q.size() == 0) begin
                checkOutput($sformatf("s%0d_queue_empty_bit%0d", stream_no, i), 16'h1, 16'h0);
                e = 1'b0;
            end else begin
                e = exp_q.pop_front();
            end
            checkOutput($sformatf("s%0d_valid%0d", stream_no, i), 16'(out_valid), 16'h1);
            checkOutput($sformatf("s%0d_busy%0d", stream_no, i),  16'(busy),      16'h1);
            checkOutput($sformatf("s%0d_bit%0d", stream_no, i),   16'(data_out),  16'(e));
            checkOutput($sformatf("s%0d_done%0d", stream_no, i),  16'(done),      16'(i == LEN - 1));
            if (i == abort_at) begin
                applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
                exp_q.delete();
                checkIdle($sformatf("s%0d_abort", stream_no));
                return;
            end
            if (i == inject_at) applyStimulus(1'b1, 4'h0, 4'hF, 1'b1, 1'b0);
            else @(negedge clk);
        end
        checkIdle($sformatf("s%0d_after", stream_no));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; addr_in = '0; data_in = '0; start = 1'b0;
        wr_en_s = 1'b0; addr_s = '0; data_s = '0; start_s = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("reset_small_valid", 16'(valid_s), 16'h0);

        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 4'(i);
            applyStimulus(1'b1, 4'(i), 4'(i), 1'b0, 1'b0);
        end

        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, -1);

        beginStream(1'b0, 4'h0, 4'h0);
        runStream(5, -1);
        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, -1);

        beginStream(1'b1, 4'h0, 4'hA);
        runStream(-1, -1);

        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, 20);
        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, -1);

        applyStimulus(1'b1, 4'h1, 4'h7, 1'b1, 1'b1);
        checkIdle("rst_priority");
        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, -1);

        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 4'h1;
            applyStimulus(1'b1, 4'(i), 4'h1, 1'b0, 1'b0);
        end
        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, -1);
        model_mem[3] = 4'h3;
        applyStimulus(1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
        beginStream(1'b0, 4'h0, 4'h0);
        runStream(-1, -1);

        wr_en_s = 1'b1; addr_s = 1'b0; data_s = 1'b1;
        @(negedge clk);
        addr_s = 1'b1; data_s = 1'b0;
        @(negedge clk);
        wr_en_s = 1'b0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        checkOutput("small_valid0", 16'(valid_s), 16'h1);
        checkOutput("small_bit0",   16'(dout_s),  16'h1);
        checkOutput("small_done0",  16'(done_s),  16'h0);
        @(negedge clk);
        checkOutput("small_valid1", 16'(valid_s), 16'h1);
        checkOutput("small_bit1",   16'(dout_s),  16'h0);
        checkOutput("small_done1",  16'(done_s),  16'(PAR == 0));
`ifdef BUFFER_SER_PARITY_EN
        @(negedge clk);
        checkOutput("small_parity", 16'(dout_s), 16'h1);
        checkOutput("small_done2",  16'(done_s), 16'h1);
`endif
        @(negedge clk);
        checkOutput("small_idle_valid", 16'(valid_s), 16'h0);
        checkOutput("small_idle_busy",  16'(busy_s),  16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
